// File: rtl/usb_host_pkg.sv
// Shared USB host definitions: PID codes and the receive-side preamble FSM states.
package usb_host_pkg;

  localparam logic [3:0] PID_PRE   = 4'hC;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_SOF   = 4'h5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRE_WAIT = 2'd1,
    FWD      = 2'd2
  } rxcp_state_t;

  // A PRE token is only absorbed when it arrived without any receiver error.
  function automatic logic is_clean_pre(input logic [3:0] pid, input logic err);
    return (pid == PID_PRE) && !err;
  endfunction

endpackage

// File: rtl/preamble_gap_timer.sv
// Down-counter that supervises the gap between an accepted PRE and the next packet.
module preamble_gap_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load wins over decrement; the count saturates at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (dec && (count != '0))
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/receive_packet_check_preamble.sv
// Absorbs PRE tokens, drives low-speed select and forwards tagged packets to the consumer.
module receive_packet_check_preamble
  import usb_host_pkg::*;
#(
  parameter int PRE_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       preAmbleEnable,
  input  logic       rxPktValid,
  input  logic [3:0] rxPktPID,
  input  logic       rxPktErr,
  output logic       rxPktRdy,
  output logic       rxPktCPValid,
  input  logic       rxPktCPReady,
  output logic [3:0] rxPktCPPID,
  output logic       rxPktCPErr,
  output logic       rxPktCPPreamble,
  output logic       lowSpeedSel,
  output logic       preTimeout,
  output logic       rxOverrun
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PRE_TIMEOUT - 1);

  rxcp_state_t state, state_next;
  logic [3:0]  pid_next;
  logic        err_next, pre_next, ls_next, timeout_next, overrun_next;
  logic        timer_load, timer_dec, timer_zero, clean_pre;

  preamble_gap_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .dec        (timer_dec),
    .load_value (RELOAD),
    .zero       (timer_zero)
  );

  assign clean_pre = preAmbleEnable && is_clean_pre(rxPktPID, rxPktErr);

  always_comb begin
    state_next   = state;
    pid_next     = rxPktCPPID;
    err_next     = rxPktCPErr;
    pre_next     = rxPktCPPreamble;
    ls_next      = lowSpeedSel;
    timeout_next = 1'b0;
    overrun_next = 1'b0;
    timer_load   = 1'b0;
    timer_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (rxPktValid) begin
          if (clean_pre) begin
            state_next = PRE_WAIT;
            ls_next    = 1'b1;
            timer_load = 1'b1;
          end else begin
            state_next = FWD;
            pid_next   = rxPktPID;
            err_next   = rxPktErr;
            pre_next   = 1'b0;
          end
        end
      end
      PRE_WAIT: begin
        timer_dec = 1'b1;
        // A strobe always beats both the timeout and the enable dropping.
        if (rxPktValid) begin
          if (clean_pre) begin
            timer_load = 1'b1;
          end else begin
            state_next = FWD;
            pid_next   = rxPktPID;
            err_next   = rxPktErr;
            pre_next   = 1'b1;
          end
        end else if (!preAmbleEnable) begin
          state_next = IDLE;
          ls_next    = 1'b0;
        end else if (timer_zero) begin
          state_next   = IDLE;
          ls_next      = 1'b0;
          timeout_next = 1'b1;
        end
      end
      FWD: begin
        overrun_next = rxPktValid;
        if (rxPktCPReady) begin
          state_next = IDLE;
          ls_next    = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        ls_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rxPktRdy        <= 1'b1;
      rxPktCPValid    <= 1'b0;
      rxPktCPPID      <= 4'h0;
      rxPktCPErr      <= 1'b0;
      rxPktCPPreamble <= 1'b0;
      lowSpeedSel     <= 1'b0;
      preTimeout      <= 1'b0;
      rxOverrun       <= 1'b0;
    end else begin
      state           <= state_next;
      rxPktRdy        <= (state_next != FWD);
      rxPktCPValid    <= (state_next == FWD);
      rxPktCPPID      <= pid_next;
      rxPktCPErr      <= err_next;
      rxPktCPPreamble <= pre_next;
      lowSpeedSel     <= ls_next;
      preTimeout      <= timeout_next;
      rxOverrun       <= overrun_next;
    end
  end

endmodule

// File: tb/tb_receive_packet_check_preamble.sv
// Scoreboard bench: expected packets are queued on stimulus and popped on each consumer handshake.
module tb_receive_packet_check_preamble;

  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pre_en = 1'b1;
  logic       rx_valid = 1'b0;
  logic [3:0] rx_pid = 4'h0;
  logic       rx_err = 1'b0;
  logic       rx_rdy;
  logic       cp_valid;
  logic       cp_ready = 1'b1;
  logic [3:0] cp_pid;
  logic       cp_err;
  logic       cp_pre;
  logic       low_speed;
  logic       pre_timeout;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int transfers = 0;
  int expected_transfers = 0;
  logic [5:0] sb[$];

  receive_packet_check_preamble #(.PRE_TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .preAmbleEnable  (pre_en),
    .rxPktValid      (rx_valid),
    .rxPktPID        (rx_pid),
    .rxPktErr        (rx_err),
    .rxPktRdy        (rx_rdy),
    .rxPktCPValid    (cp_valid),
    .rxPktCPReady    (cp_ready),
    .rxPktCPPID      (cp_pid),
    .rxPktCPErr      (cp_err),
    .rxPktCPPreamble (cp_pre),
    .lowSpeedSel     (low_speed),
    .preTimeout      (pre_timeout),
    .rxOverrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] pid, input logic err);
    rx_valid = 1'b1;
    rx_pid   = pid;
    rx_err   = err;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic expectPacket(input logic [3:0] pid, input logic err, input logic pre);
    sb.push_back({pid, err, pre});
    expected_transfers++;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rdy"}, rx_rdy, 1);
    checkOutput({tag, "_valid"}, cp_valid, 0);
    checkOutput({tag, "_pid"}, cp_pid, 0);
    checkOutput({tag, "_err"}, cp_err, 0);
    checkOutput({tag, "_pre"}, cp_pre, 0);
    checkOutput({tag, "_ls"}, low_speed, 0);
    checkOutput({tag, "_timeout"}, pre_timeout, 0);
    checkOutput({tag, "_overrun"}, overrun, 0);
  endtask

  // Consumer side: every completed handshake must match the oldest expected packet.
  always @(negedge clk) begin
    logic [5:0] exp;
    if (!rst && cp_valid && cp_ready) begin
      transfers++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_xfer", 1, 0);
      end else begin
        exp = sb.pop_front();
        checkOutput("xfer_pid", cp_pid, exp[5:2]);
        checkOutput("xfer_err", cp_err, exp[1]);
        checkOutput("xfer_pre", cp_pre, exp[0]);
      end
    end
  end

  initial begin
    tick();
    tick();
    checkResetValues("reset");
    rst = 1'b0;
    tick();

    // Plain ACK with consumer ready held high
    expectPacket(4'h2, 1'b0, 1'b0);
    applyStimulus(4'h2, 1'b0);
    checkOutput("ack_valid", cp_valid, 1);
    checkOutput("ack_rdy", rx_rdy, 0);
    checkOutput("ack_ls", low_speed, 0);
    tick();
    checkOutput("ack_valid_drop", cp_valid, 0);
    checkOutput("ack_rdy_back", rx_rdy, 1);

    // PRE then DATA0 a few cycles later
    applyStimulus(4'hC, 1'b0);
    checkOutput("pre_ls", low_speed, 1);
    checkOutput("pre_not_fwd", cp_valid, 0);
    checkOutput("pre_rdy", rx_rdy, 1);
    repeat (3) tick();
    expectPacket(4'h3, 1'b0, 1'b1);
    applyStimulus(4'h3, 1'b0);
    checkOutput("d0_valid", cp_valid, 1);
    checkOutput("d0_ls", low_speed, 1);
    tick();
    checkOutput("d0_ls_off", low_speed, 0);
    checkOutput("d0_valid_drop", cp_valid, 0);

    // PRE with no follow-up: pulse TIMEOUT+1 cycles after the strobe
    applyStimulus(4'hC, 1'b0);
    for (int i = 1; i < TIMEOUT; i++) begin
      checkOutput("gap_no_pulse", pre_timeout, 0);
      checkOutput("gap_ls", low_speed, 1);
      tick();
    end
    checkOutput("gap_no_pulse_last", pre_timeout, 0);
    tick();
    checkOutput("timeout_pulse", pre_timeout, 1);
    checkOutput("timeout_ls", low_speed, 0);
    checkOutput("timeout_rdy", rx_rdy, 1);
    tick();
    checkOutput("timeout_pulse_end", pre_timeout, 0);

    // Strobe on the counter-zero cycle: packet wins
    applyStimulus(4'hC, 1'b0);
    repeat (TIMEOUT - 1) tick();
    expectPacket(4'hE, 1'b0, 1'b1);
    applyStimulus(4'hE, 1'b0);
    checkOutput("race_no_pulse", pre_timeout, 0);
    checkOutput("race_valid", cp_valid, 1);
    tick();

    // Enable falls during PRE_WAIT with a strobe in the same cycle
    applyStimulus(4'hC, 1'b0);
    pre_en = 1'b0;
    expectPacket(4'h5, 1'b0, 1'b1);
    applyStimulus(4'h5, 1'b0);
    checkOutput("enfall_valid", cp_valid, 1);
    tick();
    pre_en = 1'b1;

    // Enable falls during PRE_WAIT without a strobe
    applyStimulus(4'hC, 1'b0);
    pre_en = 1'b0;
    tick();
    checkOutput("enfall_ls", low_speed, 0);
    checkOutput("enfall_no_pulse", pre_timeout, 0);

    // PRE forwarded when absorption is disabled
    expectPacket(4'hC, 1'b0, 1'b0);
    applyStimulus(4'hC, 1'b0);
    checkOutput("pre_dis_valid", cp_valid, 1);
    checkOutput("pre_dis_ls", low_speed, 0);
    tick();
    pre_en = 1'b1;

    // PRE with a receiver error is forwarded
    expectPacket(4'hC, 1'b1, 1'b0);
    applyStimulus(4'hC, 1'b1);
    checkOutput("pre_err_valid", cp_valid, 1);
    tick();

    // Consumer stalls; a second strobe is dropped as an overrun
    cp_ready = 1'b0;
    expectPacket(4'hB, 1'b0, 1'b0);
    applyStimulus(4'hB, 1'b0);
    tick();
    applyStimulus(4'h5, 1'b0);
    checkOutput("overrun_pulse", overrun, 1);
    checkOutput("overrun_pid", cp_pid, 4'hB);
    tick();
    checkOutput("overrun_end", overrun, 0);
    checkOutput("stall_valid", cp_valid, 1);
    cp_ready = 1'b1;
    tick();
    checkOutput("stall_done", cp_valid, 0);

    // Reset while waiting after a PRE
    applyStimulus(4'hC, 1'b0);
    rst = 1'b1;
    tick();
    checkResetValues("rst_prewait");
    rst = 1'b0;

    // Reset while holding a packet for the consumer
    cp_ready = 1'b0;
    applyStimulus(4'h2, 1'b0);
    checkOutput("rst_fwd_pre_valid", cp_valid, 1);
    rst = 1'b1;
    tick();
    checkResetValues("rst_fwd");
    rst = 1'b0;
    cp_ready = 1'b1;
    tick();

    expectPacket(4'hA, 1'b0, 1'b0);
    applyStimulus(4'hA, 1'b0);
    checkOutput("post_rst_valid", cp_valid, 1);
    checkOutput("post_rst_pid", cp_pid, 4'hA);

    repeat (5) tick();
    checkOutput("sb_empty", sb.size(), 0);
    checkOutput("xfer_count", transfers, expected_transfers);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/receive_packet_check_preamble.md
# receive_packet_check_preamble

Receive-side companion to the host's preamble-inserting send path. Sits between the USB packet receiver (PID decode, CRC and bit-stuff checks) and the packet consumer (host or slave controller). It absorbs PRE (0xC) tokens when preamble handling is enabled, asserts a low-speed select for the packet that follows, and tags that packet as preamble-prefixed. It supervises the PRE-to-packet gap with a timeout counter and uses a registered valid/ready handshake toward the consumer.

## Interface
Parameters:
- PRE_TIMEOUT, 64: max cycles from PRE acceptance to the next packet strobe; legal range 2..255.
- CNT_W, 8: timeout counter width; must hold PRE_TIMEOUT-1.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  synchronous, active-high reset.
- preAmbleEnable  in  1  enables PRE absorption.
- rxPktValid  in  1  one-cycle strobe; rxPktPID/rxPktErr are valid in that cycle.
- rxPktPID  in  4  received PID (4-bit, check nibble already verified upstream).
- rxPktErr  in  1  OR of receiver errors (PID check, CRC, bit-stuff, timeout).
- rxPktRdy  out  1  block can accept a packet strobe.
- rxPktCPValid  out  1  output packet valid (level).
- rxPktCPReady  in  1  consumer accepts the packet.
- rxPktCPPID  out  4  forwarded PID.
- rxPktCPErr  out  1  forwarded error flag.
- rxPktCPPreamble  out  1  forwarded packet followed an accepted PRE.
- lowSpeedSel  out  1  PHY low-speed select.
- preTimeout  out  1  one-cycle pulse when the PRE gap expires.
- rxOverrun  out  1  one-cycle pulse when a strobe is dropped.

## Operation
- States: IDLE, PRE_WAIT, FWD. Reset state is IDLE.
- IDLE:
  - rxPktRdy=1.
  - On rxPktValid with preAmbleEnable=1, PID=0xC and Err=0: go to PRE_WAIT, set lowSpeedSel=1, load counter with PRE_TIMEOUT-1. Nothing is forwarded.
  - On any other rxPktValid (including PRE with Err=1, or PRE with preAmbleEnable=0): latch PID/Err, set Preamble=0, go to FWD.
- PRE_WAIT:
  - rxPktRdy=1. The counter decrements once per cycle.
  - rxPktValid with a non-PRE PID, or PRE with Err=1: latch PID/Err, set Preamble=1, go to FWD. lowSpeedSel stays 1.
  - rxPktValid with a clean PRE: reload counter and stay in PRE_WAIT.
  - Counter=0 with no strobe: go to IDLE, lowSpeedSel=0, pulse preTimeout.
  - Strobe in the same cycle as counter=0: the packet wins, no timeout pulse.
  - preAmbleEnable falls: go to IDLE, lowSpeedSel=0, no pulse. A strobe in that same cycle is forwarded with Preamble=1.
- FWD:
  - rxPktRdy=0. rxPktCPValid=1 with PID/Err/Preamble held stable.
  - Handshake completes in the cycle where rxPktCPReady=1. The next cycle has rxPktCPValid=0, rxPktRdy=1, lowSpeedSel=0, state IDLE.
  - An rxPktValid strobe while in FWD is dropped and pulses rxOverrun. Latched data is unchanged.
- Reset values: rxPktRdy=1, rxPktCPValid=0, rxPktCPPID=0, rxPktCPErr=0, rxPktCPPreamble=0, lowSpeedSel=0, preTimeout=0, rxOverrun=0, counter=0.
- rst asserted mid-operation aborts any PRE_WAIT or FWD; the pending packet is lost.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Strobe in cycle N (IDLE or PRE_WAIT, forwardable) gives rxPktCPValid=1 in cycle N+1.
- rxPktCPReady may be high before valid; a transfer then occurs in the first valid cycle (valid lasts one cycle).
- PRE accepted at cycle N gives lowSpeedSel=1 at N+1. With no follow-up packet, preTimeout pulses at cycle N+PRE_TIMEOUT+1 and lowSpeedSel=0 from the same cycle.
- Counter arithmetic is unsigned, CNT_W bits, with no wrap: decrement only while non-zero.
- Maximum throughput is one packet per 2 cycles (FWD to IDLE turnaround).

## Structure
- Shared package usb_host_pkg:
  - PID constants: PID_PRE=4'hC, PID_ACK=4'h2, PID_NAK=4'hA, PID_STALL=4'hE, PID_DATA0=4'h3, PID_DATA1=4'hB, PID_SOF=4'h5.
  - State enum rxcp_state_t, encoded IDLE=2'd0, PRE_WAIT=2'd1, FWD=2'd2.
- One sub-module: preamble_gap_timer (load, decrement, zero flag; parameter CNT_W).
- FSM style: combinational next-state/next-output block plus a registered output block, matching the send path.

## Test plan
- Plain ACK: strobe PID=0x2, consumer ready held high → rxPktCPValid for 1 cycle at N+1, PID=0x2, Preamble=0, lowSpeedSel stays 0.
- PRE then DATA0 within 10 cycles, preAmbleEnable=1 → PRE not forwarded; lowSpeedSel=1 from PRE+1 through the handshake; output PID=0x3, Preamble=1.
- PRE with PRE_TIMEOUT=8 and no follow-up → preTimeout pulse exactly 9 cycles after the PRE strobe; lowSpeedSel=0; rxPktRdy=1.
- PRE with preAmbleEnable=0 → forwarded as PID=0xC, Preamble=0; PRE with Err=1 → forwarded with Err=1.
- Consumer ready held low 5 cycles, second strobe at cycle 3 → rxOverrun pulse; output PID unchanged; single transfer after ready rises.
- rst asserted while in PRE_WAIT and again while in FWD → all outputs at reset values the next cycle; the next packet is processed normally.
